// File: rtl/procyon_lsu_st_resp.sv
// procyon_lsu_st_resp
//
// Store responder for the load/store unit. It takes one retired store at a
// time from the store queue and sends it to the dcache or to the miss
// handling queue (MHQ). It then reports the outcome back to the store queue.
// Only one store is ever in flight, so the sequence is a fixed four-cycle
// walk through a small FSM.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   i_flush                   pipeline flush; drops the store in flight
//   i_sq_retire_*             store launch from the SQ (op/tag/addr/data)
//   o_sq_ready                responder idle and able to accept a store
//   o_dc_rd_en, o_dc_addr     dcache tag lookup; i_dc_hit returns next cycle
//   o_dc_wr_*                 dcache write on a hit (aligned data + lanes)
//   o_mhq_enq_*               MHQ enqueue on a miss (aligned data + lanes)
//   i_mhq_full                MHQ cannot take an enqueue this cycle
//   i_mhq_fill_en/_addr       MHQ line fill in progress (conflict detection)
//   o_update_*                one-cycle outcome report back to the SQ
//
// State table
//   state | meaning
//   IDLE  | waiting for a store from the SQ
//   DT    | dcache tag lookup issued
//   DW    | hit/full sampled, outcome resolved, write or enqueue issued
//   RESP  | outcome reported to the SQ

`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`define PCYN_OP_SB    5'h08
`define PCYN_OP_SH    5'h09
`define PCYN_OP_SW    5'h0A
`endif

module procyon_lsu_st_resp #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           i_flush,

  input  logic                           i_sq_retire_en,
  input  logic [`PCYN_OP_WIDTH-1:0]      i_sq_retire_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_sq_retire_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_sq_retire_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]     i_sq_retire_data,
  output logic                           o_sq_ready,

  output logic                           o_dc_rd_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_dc_addr,
  input  logic                           i_dc_hit,
  output logic                           o_dc_wr_en,
  output logic [OPTN_DATA_WIDTH-1:0]     o_dc_wr_data,
  output logic [OPTN_DATA_WIDTH/8-1:0]   o_dc_wr_byte_sel,

  output logic                           o_mhq_enq_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_mhq_enq_addr,
  output logic [OPTN_DATA_WIDTH-1:0]     o_mhq_enq_data,
  output logic [OPTN_DATA_WIDTH/8-1:0]   o_mhq_enq_byte_sel,
  input  logic                           i_mhq_full,
  input  logic                           i_mhq_fill_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_mhq_fill_addr,

  output logic                           o_update_en,
  output logic                           o_update_retry,
  output logic                           o_update_replay,
  output logic                           o_update_mhq_retry,
  output logic                           o_update_mhq_replay
);

  localparam int DATA_BYTES = OPTN_DATA_WIDTH / 8;
  // Cache line offset bits; addresses that agree above this belong to one line.
  localparam int LINE_LSB   = $clog2(DATA_BYTES) + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DT   = 2'd1,
    DW   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Outcome flags, packed as {retry, replay, mhq_retry, mhq_replay}
  localparam logic [3:0] FLAGS_DONE       = 4'b0000;
  localparam logic [3:0] FLAGS_REPLAY     = 4'b1100;
  localparam logic [3:0] FLAGS_MHQ_RETRY  = 4'b1010;
  localparam logic [3:0] FLAGS_MHQ_REPLAY = 4'b1001;

  state_t state_q;
  state_t state_d;

  logic                          accept;

  // Captured store, no reset needed: only read while a store is in flight
  logic [`PCYN_OP_WIDTH-1:0]     op_q;
  logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q;
  logic [OPTN_ADDR_WIDTH-1:0]    addr_q;
  logic [OPTN_DATA_WIDTH-1:0]    data_q;

  logic                          fill_match;
  logic                          conflict_q;
  logic                          conflict_dw;
  logic [3:0]                    outcome_d;
  logic [3:0]                    flags_q;

  logic [DATA_BYTES-1:0]         byte_sel;
  logic [OPTN_DATA_WIDTH-1:0]    aligned_data;

  // The tag travels with the store for debug visibility only; the SQ already
  // knows which entry it launched. The low fill address bits are line offset.
  logic                          unused;
  assign unused = ^{tag_q, i_mhq_fill_addr[LINE_LSB-1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    o_sq_ready   = 1'b0;
    o_dc_rd_en   = 1'b0;
    o_dc_wr_en   = 1'b0;
    o_mhq_enq_en = 1'b0;
    o_update_en  = 1'b0;

    case (state_q)
      IDLE: begin
        o_sq_ready = ~i_flush;
        if (i_sq_retire_en && !i_flush) begin
          accept  = 1'b1;
          state_d = DT;
        end
      end

      DT: begin
        o_dc_rd_en = 1'b1;
        state_d    = i_flush ? IDLE : DW;
      end

      DW: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          state_d      = RESP;
          // A pending fill to the same line would overwrite this store, so
          // neither write nor enqueue; the SQ replays it after the fill.
          o_dc_wr_en   = ~conflict_dw & i_dc_hit;
          o_mhq_enq_en = ~conflict_dw & ~i_dc_hit & ~i_mhq_full;
        end
      end

      RESP: begin
        state_d     = IDLE;
        o_update_en = ~i_flush;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Store capture on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= i_sq_retire_op;
      tag_q  <= i_sq_retire_tag;
      addr_q <= i_sq_retire_addr;
      data_q <= i_sq_retire_data;
    end
  end

  // Fill conflict tracking: a matching fill seen in DT is remembered so it
  // still counts when the outcome is resolved in DW.
  assign fill_match  = i_mhq_fill_en &&
                       (i_mhq_fill_addr[OPTN_ADDR_WIDTH-1:LINE_LSB] ==
                        addr_q[OPTN_ADDR_WIDTH-1:LINE_LSB]);
  assign conflict_dw = conflict_q | fill_match;

  always_ff @(posedge clk) begin
    conflict_q <= (state_q == DT) && fill_match;
  end

  // Outcome resolution, first match wins
  always_comb begin
    outcome_d = FLAGS_MHQ_RETRY;
    if (conflict_dw) begin
      outcome_d = FLAGS_REPLAY;
    end else if (i_dc_hit) begin
      outcome_d = FLAGS_DONE;
    end else if (i_mhq_full) begin
      outcome_d = FLAGS_MHQ_REPLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == DW) begin
      flags_q <= outcome_d;
    end
  end

  // Flags are forced low outside the update cycle so the SQ can read them
  // without qualifying.
  assign o_update_retry      = o_update_en & flags_q[3];
  assign o_update_replay     = o_update_en & flags_q[2];
  assign o_update_mhq_retry  = o_update_en & flags_q[1];
  assign o_update_mhq_replay = o_update_en & flags_q[0];

  // Byte lane decode and data alignment
  always_comb begin
    byte_sel     = '0;
    aligned_data = data_q;
    case (op_q)
      `PCYN_OP_SB: begin
        byte_sel     = DATA_BYTES'(1) << addr_q[1:0];
        aligned_data = data_q << {addr_q[1:0], 3'b000};
      end
      `PCYN_OP_SH: begin
        byte_sel     = DATA_BYTES'(3) << {addr_q[1], 1'b0};
        aligned_data = data_q << {addr_q[1], 4'b0000};
      end
      `PCYN_OP_SW: begin
        byte_sel = '1;
      end
      default: begin
        byte_sel = '0;
      end
    endcase
  end

  assign o_dc_addr          = addr_q;
  assign o_dc_wr_data       = aligned_data;
  assign o_dc_wr_byte_sel   = byte_sel;

  assign o_mhq_enq_addr     = addr_q;
  assign o_mhq_enq_data     = aligned_data;
  assign o_mhq_enq_byte_sel = byte_sel;

endmodule

// File: tb/tb_procyon_lsu_st_resp.sv
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`define PCYN_OP_SB    5'h08
`define PCYN_OP_SH    5'h09
`define PCYN_OP_SW    5'h0A
`endif

module tb_procyon_lsu_st_resp;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_sq_retire_en;
  logic [4:0]  i_sq_retire_op;
  logic [4:0]  i_sq_retire_tag;
  logic [31:0] i_sq_retire_addr;
  logic [31:0] i_sq_retire_data;
  logic        o_sq_ready;
  logic        o_dc_rd_en;
  logic [31:0] o_dc_addr;
  logic        i_dc_hit;
  logic        o_dc_wr_en;
  logic [31:0] o_dc_wr_data;
  logic [3:0]  o_dc_wr_byte_sel;
  logic        o_mhq_enq_en;
  logic [31:0] o_mhq_enq_addr;
  logic [31:0] o_mhq_enq_data;
  logic [3:0]  o_mhq_enq_byte_sel;
  logic        i_mhq_full;
  logic        i_mhq_fill_en;
  logic [31:0] i_mhq_fill_addr;
  logic        o_update_en;
  logic        o_update_retry;
  logic        o_update_replay;
  logic        o_update_mhq_retry;
  logic        o_update_mhq_replay;

  procyon_lsu_st_resp #(
    .OPTN_DATA_WIDTH(32),
    .OPTN_ADDR_WIDTH(32),
    .OPTN_ROB_IDX_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(i_flush),
    .i_sq_retire_en(i_sq_retire_en),
    .i_sq_retire_op(i_sq_retire_op),
    .i_sq_retire_tag(i_sq_retire_tag),
    .i_sq_retire_addr(i_sq_retire_addr),
    .i_sq_retire_data(i_sq_retire_data),
    .o_sq_ready(o_sq_ready),
    .o_dc_rd_en(o_dc_rd_en),
    .o_dc_addr(o_dc_addr),
    .i_dc_hit(i_dc_hit),
    .o_dc_wr_en(o_dc_wr_en),
    .o_dc_wr_data(o_dc_wr_data),
    .o_dc_wr_byte_sel(o_dc_wr_byte_sel),
    .o_mhq_enq_en(o_mhq_enq_en),
    .o_mhq_enq_addr(o_mhq_enq_addr),
    .o_mhq_enq_data(o_mhq_enq_data),
    .o_mhq_enq_byte_sel(o_mhq_enq_byte_sel),
    .i_mhq_full(i_mhq_full),
    .i_mhq_fill_en(i_mhq_fill_en),
    .i_mhq_fill_addr(i_mhq_fill_addr),
    .o_update_en(o_update_en),
    .o_update_retry(o_update_retry),
    .o_update_replay(o_update_replay),
    .o_update_mhq_retry(o_update_mhq_retry),
    .o_update_mhq_replay(o_update_mhq_replay)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bsel;
    logic [3:0]  flags;
  } exp_t;

  exp_t wr_q[$];
  exp_t enq_q[$];
  exp_t upd_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;
  exp_t me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write/enqueue/update the DUT makes is matched
  // against the oldest expectation; expectations that go past due are misses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_dc_wr_en) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL dc_wr_unexpected cycle=%0d addr=%h", cyc, o_dc_addr);
        end else begin
          me = wr_q.pop_front();
          if (me.cyc !== cyc || o_dc_addr !== me.addr || o_dc_wr_data !== me.data ||
              o_dc_wr_byte_sel !== me.bsel) begin
            failures++;
            $display("FAIL dc_wr got cyc=%0d addr=%h data=%h bsel=%b exp cyc=%0d addr=%h data=%h bsel=%b",
                     cyc, o_dc_addr, o_dc_wr_data, o_dc_wr_byte_sel, me.cyc, me.addr, me.data, me.bsel);
          end
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        me = wr_q.pop_front();
        $display("FAIL dc_wr_missing cycle=%0d exp_cyc=%0d", cyc, me.cyc);
      end

      if (o_mhq_enq_en) begin
        checks++;
        if (enq_q.size() == 0) begin
          failures++;
          $display("FAIL mhq_enq_unexpected cycle=%0d addr=%h", cyc, o_mhq_enq_addr);
        end else begin
          me = enq_q.pop_front();
          if (me.cyc !== cyc || o_mhq_enq_addr !== me.addr || o_mhq_enq_data !== me.data ||
              o_mhq_enq_byte_sel !== me.bsel) begin
            failures++;
            $display("FAIL mhq_enq got cyc=%0d addr=%h data=%h bsel=%b exp cyc=%0d addr=%h data=%h bsel=%b",
                     cyc, o_mhq_enq_addr, o_mhq_enq_data, o_mhq_enq_byte_sel, me.cyc, me.addr, me.data, me.bsel);
          end
        end
      end else if (enq_q.size() > 0 && enq_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        me = enq_q.pop_front();
        $display("FAIL mhq_enq_missing cycle=%0d exp_cyc=%0d", cyc, me.cyc);
      end

      if (o_update_en) begin
        checks++;
        if (upd_q.size() == 0) begin
          failures++;
          $display("FAIL update_unexpected cycle=%0d", cyc);
        end else begin
          me = upd_q.pop_front();
          if (me.cyc !== cyc || {o_update_retry, o_update_replay, o_update_mhq_retry,
              o_update_mhq_replay} !== me.flags) begin
            failures++;
            $display("FAIL update got cyc=%0d flags=%b exp cyc=%0d flags=%b", cyc,
                     {o_update_retry, o_update_replay, o_update_mhq_retry, o_update_mhq_replay},
                     me.cyc, me.flags);
          end
        end
      end else begin
        checks++;
        if ({o_update_retry, o_update_replay, o_update_mhq_retry, o_update_mhq_replay} !== 4'b0000) begin
          failures++;
          $display("FAIL update_flags_idle cycle=%0d got=%b exp=0000", cyc,
                   {o_update_retry, o_update_replay, o_update_mhq_retry, o_update_mhq_replay});
        end
        if (upd_q.size() > 0 && upd_q[0].cyc <= cyc) begin
          checks++;
          failures++;
          me = upd_q.pop_front();
          $display("FAIL update_missing cycle=%0d exp_cyc=%0d", cyc, me.cyc);
        end
      end
    end
  end

  function automatic void model(input logic [4:0] op, input logic [31:0] addr,
                                input logic [31:0] data, output logic [3:0] bs,
                                output logic [31:0] ad);
    bs = 4'b0000;
    ad = data;
    case (op)
      `PCYN_OP_SB: begin
        case (addr[1:0])
          2'd0:    bs = 4'b0001;
          2'd1:    bs = 4'b0010;
          2'd2:    bs = 4'b0100;
          default: bs = 4'b1000;
        endcase
        ad = data << (8 * addr[1:0]);
      end
      `PCYN_OP_SH: begin
        bs = addr[1] ? 4'b1100 : 4'b0011;
        ad = addr[1] ? (data << 16) : data;
      end
      `PCYN_OP_SW: bs = 4'b1111;
      default: ;
    endcase
  endfunction

  // One store through the pipe. fill_at / flush_at: 0 = never, 1 = DT, 2 = DW,
  // 3 = RESP (flush only).
  task automatic do_store(input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic hit, input logic full,
                          input int fill_at, input logic [31:0] fill_addr,
                          input int flush_at);
    int          t;
    logic [3:0]  bs;
    logic [31:0] ad;
    logic        conflict;
    logic [3:0]  flags;
    exp_t        e;
    @(posedge clk); #1;
    t = cyc;
    model(op, addr, data, bs, ad);
    conflict = (fill_at == 1 || fill_at == 2) && (fill_addr[31:4] == addr[31:4]);
    flags = conflict ? 4'b1100 : hit ? 4'b0000 : full ? 4'b1001 : 4'b1010;
    e.addr = addr; e.data = ad; e.bsel = bs; e.flags = flags;
    if (flush_at != 1 && flush_at != 2 && !conflict) begin
      e.cyc = t + 2;
      if (hit) wr_q.push_back(e);
      else if (!full) enq_q.push_back(e);
    end
    if (flush_at == 0) begin
      e.cyc = t + 3;
      upd_q.push_back(e);
    end

    i_sq_retire_en   = 1'b1;
    i_sq_retire_op   = op;
    i_sq_retire_tag  = 5'(t);
    i_sq_retire_addr = addr;
    i_sq_retire_data = data;
    #1;
    checks++;
    if (o_sq_ready !== 1'b1) begin
      failures++;
      $display("FAIL store_ready_T got=%b exp=1", o_sq_ready);
    end

    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      i_sq_retire_en  = 1'b0;
      i_mhq_fill_en   = (fill_at == k);
      i_mhq_fill_addr = fill_addr;
      i_flush         = (flush_at == k);
      i_dc_hit        = (k == 2) ? hit : 1'b0;
      i_mhq_full      = (k == 2) ? full : 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if (o_dc_rd_en !== 1'b1 || o_dc_addr !== addr || o_sq_ready !== 1'b0) begin
          failures++;
          $display("FAIL lookup_DT got rd_en=%b addr=%h ready=%b exp rd_en=1 addr=%h ready=0",
                   o_dc_rd_en, o_dc_addr, o_sq_ready, addr);
        end
      end else begin
        checks++;
        if (o_sq_ready !== ((flush_at == 1) || (k == 3 && flush_at == 2))) begin
          failures++;
          $display("FAIL busy_ready k=%0d got=%b exp=%b", k, o_sq_ready,
                   ((flush_at == 1) || (k == 3 && flush_at == 2)));
        end
      end
    end

    @(posedge clk); #1;
    i_flush       = 1'b0;
    i_mhq_fill_en = 1'b0;
    #1;
    checks++;
    if (o_sq_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after got=%b exp=1", o_sq_ready);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (o_sq_ready !== 1'b1 || o_dc_rd_en !== 1'b0 || o_dc_wr_en !== 1'b0 ||
        o_mhq_enq_en !== 1'b0 || o_update_en !== 1'b0 ||
        {o_update_retry, o_update_replay, o_update_mhq_retry, o_update_mhq_replay} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got ready=%b rd=%b wr=%b enq=%b upd=%b exp 1 0 0 0 0",
               o_sq_ready, o_dc_rd_en, o_dc_wr_en, o_mhq_enq_en, o_update_en);
    end
  endtask

  task automatic test_hit;
    do_store(`PCYN_OP_SW, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 0, 32'h0, 0);
    do_store(`PCYN_OP_SH, 32'h102, 32'h00001234, 1'b1, 1'b0, 0, 32'h0, 0);
    do_store(`PCYN_OP_SB, 32'h100, 32'h000000C3, 1'b1, 1'b1, 0, 32'h0, 0);
  endtask

  task automatic test_miss;
    do_store(`PCYN_OP_SB, 32'h103, 32'h000000AB, 1'b0, 1'b0, 0, 32'h0, 0);
    do_store(`PCYN_OP_SB, 32'h101, 32'h000000CD, 1'b0, 1'b0, 0, 32'h0, 0);
    do_store(`PCYN_OP_SH, 32'h102, 32'h00005678, 1'b0, 1'b1, 0, 32'h0, 0);
    do_store(`PCYN_OP_SH, 32'h140, 32'h00009ABC, 1'b0, 1'b0, 0, 32'h0, 0);
  endtask

  task automatic test_fill_conflict;
    do_store(`PCYN_OP_SW, 32'h104, 32'h11223344, 1'b1, 1'b0, 1, 32'h100, 0);
    do_store(`PCYN_OP_SW, 32'h104, 32'h55667788, 1'b0, 1'b1, 2, 32'h10C, 0);
    do_store(`PCYN_OP_SW, 32'h104, 32'h99AABBCC, 1'b1, 1'b0, 2, 32'h200, 0);
    do_store(`PCYN_OP_SW, 32'h104, 32'hCAFEF00D, 1'b1, 1'b0, 1, 32'h110, 0);
  endtask

  task automatic test_flush;
    do_store(`PCYN_OP_SW, 32'h180, 32'h01020304, 1'b1, 1'b0, 0, 32'h0, 2);
    do_store(`PCYN_OP_SW, 32'h184, 32'h05060708, 1'b0, 1'b0, 0, 32'h0, 1);
    do_store(`PCYN_OP_SW, 32'h188, 32'h090A0B0C, 1'b1, 1'b0, 0, 32'h0, 3);
  endtask

  task automatic test_flush_idle;
    @(posedge clk); #1;
    i_flush          = 1'b1;
    i_sq_retire_en   = 1'b1;
    i_sq_retire_op   = `PCYN_OP_SW;
    i_sq_retire_addr = 32'h1C0;
    i_sq_retire_data = 32'h0BADF00D;
    i_dc_hit         = 1'b1;
    #1;
    checks++;
    if (o_sq_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_ready got=%b exp=0", o_sq_ready);
    end
    @(posedge clk); #1;
    i_flush        = 1'b0;
    i_sq_retire_en = 1'b0;
    #1;
    checks++;
    if (o_dc_rd_en !== 1'b0 || o_sq_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_accept got rd_en=%b ready=%b exp rd_en=0 ready=1",
               o_dc_rd_en, o_sq_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    i_dc_hit = 1'b0;
  endtask

  task automatic test_back_to_back;
    int   t;
    exp_t e;
    @(posedge clk); #1;
    t = cyc;
    e.addr = 32'h200; e.data = 32'h11112222; e.bsel = 4'b1111; e.flags = 4'b0000;
    e.cyc = t + 2; wr_q.push_back(e);
    e.cyc = t + 3; upd_q.push_back(e);
    e.addr = 32'h205; e.data = 32'h00005A00; e.bsel = 4'b0010;
    e.cyc = t + 6; wr_q.push_back(e);
    e.cyc = t + 7; upd_q.push_back(e);

    i_sq_retire_en   = 1'b1;
    i_sq_retire_op   = `PCYN_OP_SW;
    i_sq_retire_addr = 32'h200;
    i_sq_retire_data = 32'h11112222;
    i_dc_hit         = 1'b1;
    #1;
    checks++;
    if (o_sq_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready k=0 got=%b exp=1", o_sq_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        i_sq_retire_op   = `PCYN_OP_SB;
        i_sq_retire_addr = 32'h205;
        i_sq_retire_data = 32'h0000005A;
      end
      #1;
      checks++;
      if (o_sq_ready !== (k == 4)) begin
        failures++;
        $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, o_sq_ready, (k == 4));
      end
    end
    @(posedge clk); #1;
    i_sq_retire_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_dc_hit = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    i_sq_retire_en   = 1'b1;
    i_sq_retire_op   = `PCYN_OP_SW;
    i_sq_retire_addr = 32'h300;
    i_sq_retire_data = 32'h12345678;
    i_dc_hit         = 1'b1;
    @(posedge clk); #1;
    i_sq_retire_en = 1'b0;
    rst            = 1'b1;
    #1;
    checks++;
    if (o_dc_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_DT got rd_en=%b exp=1", o_dc_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (o_sq_ready !== 1'b1 || o_dc_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle got ready=%b rd_en=%b exp ready=1 rd_en=0",
               o_sq_ready, o_dc_rd_en);
    end
    repeat (4) @(posedge clk);
    #1;
    i_dc_hit = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    i_flush          = 1'b0;
    i_sq_retire_en   = 1'b0;
    i_sq_retire_op   = 5'h0;
    i_sq_retire_tag  = 5'h0;
    i_sq_retire_addr = 32'h0;
    i_sq_retire_data = 32'h0;
    i_dc_hit         = 1'b0;
    i_mhq_full       = 1'b0;
    i_mhq_fill_en    = 1'b0;
    i_mhq_fill_addr  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    test_reset();
    test_hit();
    test_miss();
    test_fill_conflict();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_q.size() + enq_q.size() + upd_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d exp=0",
               wr_q.size() + enq_q.size() + upd_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/procyon_lsu_st_resp.md
PROCYON_LSU_ST_RESP -- requirements
Module: procyon_lsu_st_resp

Interface
REQ-001 SHALL have parameters OPTN_DATA_WIDTH (32, data bits), OPTN_ADDR_WIDTH (32, address bits) and OPTN_ROB_IDX_WIDTH (5, ROB tag bits), one per line as listed.
REQ-002 SHALL use one clock; reset is synchronous and active-high: clk input 1 (rising-edge clock), rst input 1 (sync active-high reset).
REQ-003 SHALL have i_flush input 1: pipeline flush.
REQ-004 SHALL have the SQ launch port:
- i_sq_retire_en in 1
- i_sq_retire_op in `PCYN_OP_WIDTH
- i_sq_retire_tag in OPTN_ROB_IDX_WIDTH
- i_sq_retire_addr in OPTN_ADDR_WIDTH
- i_sq_retire_data in OPTN_DATA_WIDTH
- o_sq_ready out 1: responder can accept a store.
REQ-005 SHALL have the dcache port:
- o_dc_rd_en out 1
- o_dc_addr out OPTN_ADDR_WIDTH
- i_dc_hit in 1: valid the cycle after o_dc_rd_en.
- o_dc_wr_en out 1
- o_dc_wr_data out OPTN_DATA_WIDTH
- o_dc_wr_byte_sel out OPTN_DATA_WIDTH/8
REQ-006 SHALL have the MHQ port:
- o_mhq_enq_en out 1
- o_mhq_enq_addr out OPTN_ADDR_WIDTH
- o_mhq_enq_data out OPTN_DATA_WIDTH
- o_mhq_enq_byte_sel out OPTN_DATA_WIDTH/8
- i_mhq_full in 1
- i_mhq_fill_en in 1
- i_mhq_fill_addr in OPTN_ADDR_WIDTH
REQ-007 SHALL have the SQ update port: o_update_en, o_update_retry, o_update_replay, o_update_mhq_retry, o_update_mhq_replay, each out 1.

Function
REQ-008 SHALL implement FSM IDLE -> DT -> DW -> RESP -> IDLE, with exactly one store in flight.
REQ-009 o_sq_ready SHALL be 1 only in IDLE; i_sq_retire_en in IDLE (cycle T) SHALL capture op/tag/addr/data and move to DT at T+1.
REQ-010 DT (T+1) SHALL assert o_dc_rd_en=1 with o_dc_addr=captured addr.
REQ-011 DW (T+2) SHALL sample i_dc_hit and i_mhq_full and resolve one outcome, first match wins:
- fill conflict: i_mhq_fill_en during DT or DW, with fill addr equal to captured addr in bits [ADDR-1:log2(DATA/8)+2]... [line compare on bits above offset 4] -> REPLAY.
- i_dc_hit -> DONE.
- miss and i_mhq_full -> MHQ_REPLAY.
- miss otherwise -> MHQ_RETRY.
REQ-012 DONE SHALL assert o_dc_wr_en for exactly one cycle in DW, with aligned data and byte_sel.
REQ-013 MHQ_RETRY SHALL assert o_mhq_enq_en for exactly one cycle in DW, with aligned data and byte_sel.
REQ-014 RESP (T+3) SHALL assert o_update_en=1 for exactly one cycle, with flags {retry, replay, mhq_retry, mhq_replay}:
- DONE = 0000
- REPLAY = 1100
- MHQ_RETRY = 1010
- MHQ_REPLAY = 1001
REQ-015 All update flags SHALL be 0 whenever o_update_en=0.
REQ-016 Byte select SHALL be decoded from op and addr[1:0]:
- SB: 1 lane, selected by addr[1:0]
- SH: 2 lanes, selected by addr[1]
- SW: 4'b1111
- any other op: 0
REQ-017 Store data SHALL be shifted left by 8*addr[1:0] bits for SB and by 16*addr[1] bits for SH.
REQ-018 i_flush in DT, DW or RESP SHALL return the FSM to IDLE next cycle and suppress o_update_en, o_dc_wr_en and o_mhq_enq_en in that cycle; a store is never half-committed.
REQ-019 i_flush in IDLE SHALL block acceptance that cycle (o_sq_ready=0).
REQ-020 i_sq_retire_en while o_sq_ready=0 SHALL be ignored.
REQ-021 A new store SHALL be accepted no earlier than T+4; back-to-back throughput is one store per 4 cycles.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, regardless of the current state.
REQ-023 After reset SHALL hold o_sq_ready=1 and o_dc_rd_en, o_dc_wr_en, o_mhq_enq_en, o_update_en and all update flags =0.
REQ-024 Reset mid-operation SHALL drop the store with no update and no write.
REQ-025 Datapath capture registers need no reset.

Verification
REQ-026 Hit: SW at addr 0x100, data 0xDEADBEEF, i_dc_hit=1 -> o_dc_wr_en at T+2 with byte_sel 1111; o_update_en at T+3 with flags 0000.
REQ-027 Miss, MHQ not full: SB at 0x103, data 0xAB -> o_mhq_enq_en at T+2 with byte_sel 1000 and data 0xAB000000; flags 1010 at T+3.
REQ-028 Miss with i_mhq_full=1: SH at 0x102 -> no write or enqueue; flags 1001 at T+3.
REQ-029 Fill conflict: i_mhq_fill_en with fill addr 0x100 during DT, store at 0x104, i_dc_hit=1 -> no dcache write; flags 1100.
REQ-030 Flush in DW: no write or update; o_sq_ready=1 at the next cycle.
REQ-031 Retire during busy: i_sq_retire_en held high T..T+5 -> second capture at T+4 with update at T+7; reset asserted in DT -> IDLE next cycle with no update.
